// File: rtl/apb_reg_initiator_pkg.sv
// Shared register-path types for the APB register initiator.
package apb_reg_initiator_pkg;

    localparam int unsigned APB_ADDR_W          = 32;
    localparam int unsigned APB_DATA_W          = 32;
    localparam int unsigned TIMEOUT_CYCLES_DFLT = 64;

    // Command carried on the request channel.
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apbReqSt;

    // Result carried on the response channel.
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  slverr;
        logic                  timeout;
    } apbRspSt;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_state_e;

endpackage

// File: rtl/apb_reg_initiator_if.sv
// Ready/valid channel and APB3 bus interfaces used by the register initiator.

// Generic ready/valid channel carrying a flat payload.
interface rdy_vld_if #(
    parameter int unsigned W = 1
);
    logic         vld;
    logic         rdy;
    logic [W-1:0] pld;

    modport src (output vld, output pld, input  rdy);
    modport dst (input  vld, input  pld, output rdy);
endinterface

// APB3 bus: src is the requester, dst is the register target.
interface apb_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport src (
        output paddr, output psel, output penable, output pwrite, output pwdata,
        input  prdata, input  pready, input  pslverr
    );
    modport dst (
        input  paddr, input  psel, input  penable, input  pwrite, input  pwdata,
        output prdata, output pready, output pslverr
    );
endinterface

// File: rtl/apb_reg_initiator.sv
// APB3 register requester: one command in, one APB transfer, one response out,
// with a bounded wait so a stalled target cannot hang the requester.
module apb_reg_initiator
    import apb_reg_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W         = APB_ADDR_W,
    parameter int unsigned DATA_W         = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
    parameter int unsigned ERRCNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    rdy_vld_if.dst              regReq,
    rdy_vld_if.src              regRsp,
    apb_if.src                  apbReg,
    output logic [ERRCNT_W-1:0] errCount
);

    // Wait counter is wide enough to hold TIMEOUT_CYCLES itself, so it never wraps.
    localparam int unsigned     WCNT_W     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(TIMEOUT_CYCLES);

    apb_state_e          state_q, state_d;
    logic                req_rdy_q, req_rdy_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_slverr_q, rsp_slverr_d;
    logic                rsp_timeout_q, rsp_timeout_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic [WCNT_W-1:0]   wcnt_inc;

    assign wcnt_inc = wcnt_q + WCNT_W'(1);

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        wcnt_d        = wcnt_q;
        errcnt_d      = errcnt_q;

        case (state_q)
            ST_IDLE: begin
                // req_rdy_q is only high in IDLE, and low for the first cycle after reset.
                if (regReq.vld && req_rdy_q) begin
                    state_d  = ST_SETUP;
                    paddr_d  = regReq.pld[DATA_W +: ADDR_W] & ~ADDR_W'(3);
                    pwrite_d = regReq.pld[ADDR_W + DATA_W];
                    pwdata_d = regReq.pld[DATA_W-1:0];
                    wcnt_d   = '0;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // pready takes priority over a timeout reached in the same cycle.
                if (apbReg.pready) begin
                    state_d       = ST_RESP;
                    rsp_rdata_d   = pwrite_q ? '0 : apbReg.prdata;
                    rsp_slverr_d  = apbReg.pslverr;
                    rsp_timeout_d = 1'b0;
                end else begin
                    if (wcnt_q != '1) begin
                        wcnt_d = wcnt_inc;
                    end
                    if ((TIMEOUT_CYCLES != 0) && (wcnt_inc == WCNT_LIMIT)) begin
                        state_d       = ST_RESP;
                        rsp_rdata_d   = '0;
                        rsp_slverr_d  = 1'b1;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (regRsp.rdy) begin
                    state_d = ST_IDLE;
                    if (rsp_slverr_q && (errcnt_q != '1)) begin
                        errcnt_d = errcnt_q + ERRCNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_rdy_d = (state_d == ST_IDLE);
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
        rsp_vld_d = (state_d == ST_RESP);
    end

    // State and output registers; reset drops the bus and discards any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            req_rdy_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_vld_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wcnt_q        <= '0;
            errcnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_rdy_q     <= req_rdy_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_vld_q     <= rsp_vld_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            wcnt_q        <= wcnt_d;
            errcnt_q      <= errcnt_d;
        end
    end

    assign regReq.rdy     = req_rdy_q;
    assign regRsp.vld     = rsp_vld_q;
    assign regRsp.pld     = {rsp_rdata_q, rsp_slverr_q, rsp_timeout_q};
    assign apbReg.paddr   = paddr_q;
    assign apbReg.psel    = psel_q;
    assign apbReg.penable = penable_q;
    assign apbReg.pwrite  = pwrite_q;
    assign apbReg.pwdata  = pwdata_q;
    assign errCount       = errcnt_q;

endmodule

// File: tb/tb_apb_reg_initiator.sv
// Randomized self-checking bench for apb_reg_initiator against a transaction-level model.
module tb_apb_reg_initiator;
    import apb_reg_initiator_pkg::*;

    localparam int unsigned TO     = 4;
    localparam int unsigned ECW    = 3;
    localparam int unsigned EC_MAX = (1 << ECW) - 1;

    logic clk;
    logic rst_n;

    rdy_vld_if #(.W(65)) req_if ();
    rdy_vld_if #(.W(34)) rsp_if ();
    apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();
    logic [ECW-1:0] err_count;

    apb_reg_initiator #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(TO),
        .ERRCNT_W(ECW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .regReq(req_if),
        .regRsp(rsp_if),
        .apbReg(apb),
        .errCount(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;
    int unsigned exp_ecnt;
    logic [31:0] mem [logic [31:0]];

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Target register contents: written words persist, unwritten words have a fixed pattern.
    function automatic logic [31:0] model_read(input logic [31:0] ka);
        if (mem.exists(ka)) return mem[ka];
        return ka ^ 32'hC0DE_0000;
    endfunction

    task automatic check_bus_active(input string ph, input logic pen, input logic [31:0] ka,
                                    input logic w, input logic [31:0] d);
        check_val({ph, "_psel"}, 64'(apb.psel), 64'(1));
        check_val({ph, "_penable"}, 64'(apb.penable), 64'(pen));
        check_val({ph, "_paddr"}, 64'(apb.paddr), 64'(ka));
        check_val({ph, "_pwrite"}, 64'(apb.pwrite), 64'(w));
        check_val({ph, "_pwdata"}, 64'(apb.pwdata), 64'(d));
        check_val({ph, "_req_rdy"}, 64'(req_if.rdy), 64'(0));
        check_val({ph, "_rsp_vld"}, 64'(rsp_if.vld), 64'(0));
    endtask

    // One full command, entered and left at a negedge with the DUT idle.
    // waits: low-pready cycles the target inserts; hold: cycles regRsp.rdy stays low;
    // pre: present the next command on regReq while the response is stalled.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input int unsigned waits, input logic err, input int unsigned hold,
                           input logic pre, input logic pw, input logic [31:0] pa,
                           input logic [31:0] pd);
        logic [31:0] ka;
        logic [31:0] rd_drv;
        logic [31:0] exp_rd;
        logic        exp_to;
        logic        exp_err;
        int unsigned n_acc;
        apbRspSt     r;

        ka     = a & ~32'h3;
        exp_to = (waits >= TO);
        n_acc  = exp_to ? TO : waits + 1;
        rd_drv = '0;

        req_if.vld = 1'b1;
        req_if.pld = apbReqSt'{write: w, addr: a, wdata: d};
        check_val("idle_req_rdy", 64'(req_if.rdy), 64'(1));

        @(negedge clk);
        req_if.vld = 1'b0;
        check_bus_active("setup", 1'b0, ka, w, d);

        for (int unsigned k = 0; k < n_acc; k++) begin
            @(negedge clk);
            check_bus_active("access", 1'b1, ka, w, d);
            if (!exp_to && k == waits) begin
                apb.pready  = 1'b1;
                apb.pslverr = err;
                apb.prdata  = w ? 32'($urandom) : model_read(ka);
                rd_drv      = apb.prdata;
            end else begin
                apb.pready  = 1'b0;
                apb.pslverr = 1'($urandom);
                apb.prdata  = 32'($urandom);
            end
        end

        exp_err = exp_to | err;
        exp_rd  = (exp_to || w) ? 32'h0 : rd_drv;
        if (w && !exp_err) mem[ka] = d;

        @(negedge clk);
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        for (int unsigned h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            r = rsp_if.pld;
            check_val("resp_vld", 64'(rsp_if.vld), 64'(1));
            check_val("resp_rdata", 64'(r.rdata), 64'(exp_rd));
            check_val("resp_slverr", 64'(r.slverr), 64'(exp_err));
            check_val("resp_timeout", 64'(r.timeout), 64'(exp_to));
            check_val("resp_psel", 64'(apb.psel), 64'(0));
            check_val("resp_penable", 64'(apb.penable), 64'(0));
            check_val("resp_req_rdy", 64'(req_if.rdy), 64'(0));
            // A late pready after a timeout must not disturb anything.
            apb.pready = exp_to && (h == 0);
            if (pre && h == 0) begin
                req_if.vld = 1'b1;
                req_if.pld = apbReqSt'{write: pw, addr: pa, wdata: pd};
            end
            rsp_if.rdy = (h == hold);
        end

        @(negedge clk);
        rsp_if.rdy = 1'b0;
        apb.pready = 1'b0;
        if (exp_err && exp_ecnt != EC_MAX) exp_ecnt++;
        check_val("done_rsp_vld", 64'(rsp_if.vld), 64'(0));
        check_val("done_psel", 64'(apb.psel), 64'(0));
        check_val("done_errcount", 64'(err_count), 64'(exp_ecnt));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        exp_ecnt   = 0;
        rst_n      = 1'b0;
        req_if.vld = 1'b0;
        req_if.pld = '0;
        rsp_if.rdy = 1'b0;
        apb.pready  = 1'b0;
        apb.prdata  = '0;
        apb.pslverr = 1'b0;
        mem[32'h4]  = 32'h1234_5678;

        #1;
        check_val("rst_req_rdy", 64'(req_if.rdy), 64'(0));
        check_val("rst_rsp_vld", 64'(rsp_if.vld), 64'(0));
        check_val("rst_psel", 64'(apb.psel), 64'(0));
        check_val("rst_penable", 64'(apb.penable), 64'(0));
        check_val("rst_pwrite", 64'(apb.pwrite), 64'(0));
        check_val("rst_paddr", 64'(apb.paddr), 64'(0));
        check_val("rst_pwdata", 64'(apb.pwdata), 64'(0));
        check_val("rst_errcount", 64'(err_count), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed: zero-wait write, 3-wait read, slave error, timeout with late pready.
        run_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 32'h04, 32'h0, 3, 1'b0, 0, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 32'h08, 32'h0, 1, 1'b1, 1, 1'b0, 1'b0, '0, '0);
        run_txn(1'b0, 32'h0C, 32'h0, 6, 1'b0, 2, 1'b0, 1'b0, '0, '0);
        // Backpressure with a second command waiting, then that command (reads back 0x10).
        run_txn(1'b1, 32'h23, 32'h0BAD_F00D, 2, 1'b0, 10, 1'b1, 1'b0, 32'h11, 32'h0);
        run_txn(1'b0, 32'h11, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, '0, '0);

        // Randomized traffic, including waits that meet or exceed the timeout.
        for (int unsigned i = 0; i < 60; i++) begin
            run_txn(1'($urandom), 32'($urandom & 32'h3F), 32'($urandom),
                    $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 3), 1'b0, 1'b0, '0, '0);
        end

        // Asynchronous reset while in ACCESS.
        req_if.vld = 1'b1;
        req_if.pld = apbReqSt'{write: 1'b0, addr: 32'h8, wdata: 32'h0};
        @(negedge clk);
        req_if.vld = 1'b0;
        @(negedge clk);
        check_val("pre_rst_penable", 64'(apb.penable), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_psel", 64'(apb.psel), 64'(0));
        check_val("arst_penable", 64'(apb.penable), 64'(0));
        check_val("arst_rsp_vld", 64'(rsp_if.vld), 64'(0));
        check_val("arst_req_rdy", 64'(req_if.rdy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_ecnt = 0;
        @(negedge clk);
        check_val("post_rst_req_rdy", 64'(req_if.rdy), 64'(1));
        check_val("post_rst_errcount", 64'(err_count), 64'(exp_ecnt));
        check_val("post_rst_rsp_vld", 64'(rsp_if.vld), 64'(0));
        run_txn(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, 1'b0, 1'b0, '0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
